armleobus_burst_mem: RTL
========================

Name: armleobus_burst_mem

Overview:
- Parametrised successor of the single-beat armleobus scratch memory used by the cache benches.
- Word-addressed armleobus slave with:
  - configurable depth, data width, access latency and inter-beat gap
  - wrapping-free incrementing bursts
  - a runtime error window for access-fault injection
- Sits behind corevx_cache, or any armleobus master, in cache/PTW benches and FPGA bring-up builds.

Parameters:
- ADDR_WIDTH, 16, word-address bits; depth = 2**ADDR_WIDTH words.
- DATA_BYTES, 4, bytes per word; data width = 8*DATA_BYTES; must be a power of two.
- FIRST_LATENCY, 2, cycles from transaction accept to first transaction_done (>=1).
- BEAT_GAP, 0, idle cycles between consecutive burst beats (>=0).
- MAX_BURST, 8, largest legal burstcount (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- transaction  in  1  request valid; held high by master until final transaction_done
- cmd  in  3  armleobus_defs.svh command encoding (READ / WRITE)
- address  in  ADDR_WIDTH+log2(DATA_BYTES)  byte address of first beat; held stable for whole burst
- burstcount  in  4  number of beats
- wdata  in  8*DATA_BYTES  write data for current beat
- wbyte_enable  in  DATA_BYTES  byte strobes for current beat
- transaction_done  out  1  one-cycle pulse per completed beat
- transaction_response  out  3  valid while transaction_done=1
- rdata  out  8*DATA_BYTES  read data, valid while transaction_done=1
- err_en  in  1  enable error window
- err_base  in  ADDR_WIDTH  first faulting word index
- err_limit  in  ADDR_WIDTH  last faulting word index (inclusive)

Behaviour:
- Reset: state IDLE; transaction_done=0; transaction_response=SUCCESS; rdata=0; beat and latency counters=0. Memory contents are not cleared.
- Reset asserted mid-burst aborts the burst; no further done pulses occur; writes already committed remain.
- FSM states: IDLE, LAT, BEAT, GAP, DRAIN.
- IDLE:
  - On transaction=1, latch cmd, word index (address>>log2(DATA_BYTES)) and burstcount.
  - Load latency counter with FIRST_LATENCY-1; go to LAT (or directly to BEAT if FIRST_LATENCY=1).
- Request check at accept:
  - Misaligned address, cmd not READ/WRITE, burstcount=0, or burstcount>MAX_BURST: single done pulse with INVALID_OPERATION after FIRST_LATENCY; no memory access; go to DRAIN.
- LAT: decrement counter; at 0 go to BEAT.
- BEAT, for current word index w:
  - Fault if w lies in the error window (err_en=1 and err_base<=w<=err_limit).
  - Fault if w has wrapped past depth-1; index arithmetic is ADDR_WIDTH+1 bits with no wrap.
  - On fault: done with UNKNOWN_ADDRESS; no write; burst terminated; go to DRAIN.
  - Otherwise: done with SUCCESS.
    - READ: rdata=mem[w].
    - WRITE: mem[w] byte lanes where wbyte_enable=1 take wdata.
  - Increment w and beat count.
  - Last beat: go to DRAIN. Else go to GAP (BEAT_GAP>0) or stay in BEAT.
- GAP: count BEAT_GAP cycles, then return to BEAT.
- DRAIN: wait until transaction=0, then go to IDLE. The slave never accepts back-to-back transactions without an intervening transaction-low cycle.
- Master drops transaction mid-burst (protocol violation): return to IDLE next cycle; no further beats.
- Error window and err_en are sampled per beat; changes take effect on the next beat.
- Minimum burst duration: FIRST_LATENCY + (burstcount-1)*(1+BEAT_GAP) cycles.

Optional Feature:
- Macro: ARMLEOBUS_BURST_MEM_STATS_EN.
- Defined: adds three 32-bit outputs:
  - stat_read_beats: successful read beats
  - stat_write_beats: successful write beats
  - stat_errors: error responses of either type
  - All saturate at 32'hFFFFFFFF and are cleared by rst.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Single write 32'h0000_0001 to byte address 0x184 (burstcount=1, strobes 4'hF), then read it back -> done exactly FIRST_LATENCY=2 cycles after accept; response SUCCESS; rdata=32'h0000_0001.
- Write burst of 8 beats at 0x200 with data 0..7 and BEAT_GAP=1, then read burst of 8 -> 8 done pulses spaced 2 cycles apart; rdata sequence 0..7.
- Partial strobe: write 32'hAABBCCDD full, then 32'h11223344 with strobes 4'b0101 -> read returns 32'hAA22CC44.
- err_en=1, err_base=err_limit=0x82, 4-beat read at word 0x80 -> beats 0x80 and 0x81 SUCCESS, third beat UNKNOWN_ADDRESS, no fourth pulse.
- burstcount=0, burstcount=9, and address 0x3 -> single INVALID_OPERATION response each; memory unchanged.
- Reset asserted on second beat of a 4-beat write -> done low the cycle after reset; beat 1 written, beats 2-4 unchanged; next transaction accepted normally.

Source files
------------

// File: rtl/armleobus_burst_mem.sv
// ============================================================================
// armleobus_burst_mem
// ----------------------------------------------------------------------------
// Word-addressed armleobus slave memory. It supports incrementing bursts
// (no wrap), a configurable first-beat latency and inter-beat gap, and a
// runtime error window that lets a testbench inject access faults.
//
// Optional feature macro: ARMLEOBUS_BURST_MEM_STATS_EN
//   When defined, the slave adds stat_read_beats, stat_write_beats and
//   stat_errors. These are saturating 32-bit counters that rst clears.
//
// Encodings follow armleobus_defs.svh:
//   cmd      : READ = 3'd1, WRITE = 3'd2
//   response : SUCCESS = 3'd0, UNKNOWN_ADDRESS = 3'd1, INVALID_OPERATION = 3'd2
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   transaction           request valid, held until the final transaction_done
//   cmd, address          command and byte address of the first beat
//   burstcount            number of beats (1..MAX_BURST)
//   wdata, wbyte_enable   write data and byte strobes for the current beat
//   transaction_done      one-cycle pulse per completed beat
//   transaction_response  response code, valid while transaction_done=1
//   rdata                 read data, valid while transaction_done=1
//   err_en, err_base,     error window; word indices err_base..err_limit
//   err_limit             fault when err_en=1
// ============================================================================
module armleobus_burst_mem #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_BYTES    = 4,
    parameter int FIRST_LATENCY = 2,
    parameter int BEAT_GAP      = 0,
    parameter int MAX_BURST     = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  transaction,
    input  logic [2:0]                            cmd,
    input  logic [ADDR_WIDTH+$clog2(DATA_BYTES)-1:0] address,
    input  logic [3:0]                            burstcount,
    input  logic [8*DATA_BYTES-1:0]               wdata,
    input  logic [DATA_BYTES-1:0]                 wbyte_enable,
    output logic                                  transaction_done,
    output logic [2:0]                            transaction_response,
    output logic [8*DATA_BYTES-1:0]               rdata,
    input  logic                                  err_en,
    input  logic [ADDR_WIDTH-1:0]                 err_base,
    input  logic [ADDR_WIDTH-1:0]                 err_limit
`ifdef ARMLEOBUS_BURST_MEM_STATS_EN
    ,
    output logic [31:0]                           stat_read_beats,
    output logic [31:0]                           stat_write_beats,
    output logic [31:0]                           stat_errors
`endif
);

    localparam int OFF   = $clog2(DATA_BYTES);
    localparam int AW    = ADDR_WIDTH + OFF;
    localparam int W     = 8 * DATA_BYTES;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [2:0] CMD_READ          = 3'd1;
    localparam logic [2:0] CMD_WRITE         = 3'd2;
    localparam logic [2:0] RESP_SUCCESS      = 3'd0;
    localparam logic [2:0] RESP_UNKNOWN_ADDR = 3'd1;
    localparam logic [2:0] RESP_INVALID_OP   = 3'd2;

    localparam logic [15:0] LAT_INIT = 16'(FIRST_LATENCY - 1);
    localparam logic [15:0] GAP_INIT = 16'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LAT,
        BEAT,
        GAP,
        DRAIN
    } state_t;

    state_t              state;
    logic [2:0]          cmd_q;
    logic [ADDR_WIDTH:0] word_q;
    logic [3:0]          bc_q;
    logic [3:0]          beat_cnt;
    logic [15:0]         lat_cnt;
    logic [15:0]         gap_cnt;
    logic                invalid_q;

    logic [W-1:0]        mem [0:DEPTH-1];

    logic misaligned;
    logic req_invalid;
    logic beat_fault;
    logic last_beat;
    logic mem_we;

    // Request screening happens at accept time. The result is latched so
    // that the bad request still answers after the normal first latency.
    assign misaligned  = |(address & AW'((1 << OFF) - 1));
    assign req_invalid = misaligned
                       || !(cmd == CMD_READ || cmd == CMD_WRITE)
                       || (burstcount == 4'd0)
                       || (burstcount > 4'(MAX_BURST));

    // The word index carries one extra bit, so running past the top of
    // memory shows up as a set MSB and is never silently wrapped.
    assign beat_fault = word_q[ADDR_WIDTH]
                      || (err_en && (word_q[ADDR_WIDTH-1:0] >= err_base)
                                 && (word_q[ADDR_WIDTH-1:0] <= err_limit));
    assign last_beat  = ((beat_cnt + 4'd1) == bc_q);

    assign mem_we = !rst && (state == BEAT) && transaction && !invalid_q
                  && !beat_fault && (cmd_q == CMD_WRITE);

    // Memory array: kept out of the reset domain, so reset never clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (wbyte_enable[b]) begin
                    mem[word_q[ADDR_WIDTH-1:0]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            transaction_done     <= 1'b0;
            transaction_response <= RESP_SUCCESS;
            rdata                <= '0;
            lat_cnt              <= '0;
            gap_cnt              <= '0;
            beat_cnt             <= '0;
            cmd_q                <= '0;
            word_q               <= '0;
            bc_q                 <= '0;
            invalid_q            <= 1'b0;
`ifdef ARMLEOBUS_BURST_MEM_STATS_EN
            stat_read_beats      <= '0;
            stat_write_beats     <= '0;
            stat_errors          <= '0;
`endif
        end else begin
            transaction_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (transaction) begin
                        cmd_q     <= cmd;
                        word_q    <= {1'b0, address[AW-1:OFF]};
                        bc_q      <= burstcount;
                        invalid_q <= req_invalid;
                        beat_cnt  <= '0;
                        lat_cnt   <= LAT_INIT;
                        state     <= (FIRST_LATENCY == 1) ? BEAT : LAT;
                    end
                end
                // The transition happens on the cycle the counter reaches
                // zero, so the first done arrives FIRST_LATENCY cycles
                // after accept.
                LAT: begin
                    if (!transaction) begin
                        state <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 16'd1;
                        if (lat_cnt <= 16'd1) begin
                            state <= BEAT;
                        end
                    end
                end
                BEAT: begin
                    if (!transaction) begin
                        state <= IDLE;
                    end else begin
                        transaction_done <= 1'b1;
                        if (invalid_q) begin
                            transaction_response <= RESP_INVALID_OP;
                            state                <= DRAIN;
`ifdef ARMLEOBUS_BURST_MEM_STATS_EN
                            if (stat_errors != '1) stat_errors <= stat_errors + 32'd1;
`endif
                        end else if (beat_fault) begin
                            transaction_response <= RESP_UNKNOWN_ADDR;
                            state                <= DRAIN;
`ifdef ARMLEOBUS_BURST_MEM_STATS_EN
                            if (stat_errors != '1) stat_errors <= stat_errors + 32'd1;
`endif
                        end else begin
                            transaction_response <= RESP_SUCCESS;
                            if (cmd_q == CMD_READ) begin
                                rdata <= mem[word_q[ADDR_WIDTH-1:0]];
                            end
`ifdef ARMLEOBUS_BURST_MEM_STATS_EN
                            if (cmd_q == CMD_READ) begin
                                if (stat_read_beats != '1) stat_read_beats <= stat_read_beats + 32'd1;
                            end else begin
                                if (stat_write_beats != '1) stat_write_beats <= stat_write_beats + 32'd1;
                            end
`endif
                            word_q   <= word_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                            beat_cnt <= beat_cnt + 4'd1;
                            if (last_beat) begin
                                state <= DRAIN;
                            end else if (BEAT_GAP > 0) begin
                                gap_cnt <= GAP_INIT;
                                state   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (!transaction) begin
                        state <= IDLE;
                    end else if (gap_cnt == 16'd0) begin
                        state <= BEAT;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                // The master has to drop transaction before the slave
                // accepts another request.
                DRAIN: begin
                    if (!transaction) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
